// File: rtl/rv_muldiv_seq.sv
// rtl/rv_muldiv_seq.sv - sequential RISC-V M-extension multiply/divide unit
//
// Purpose: executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU at WIDTH bits,
// UNROLL iteration steps per clock. Operands are captured as magnitudes on
// the accepting edge. The sign is restored in a final FIX cycle.
//
// Optional build macro: MULDIV_FAST_EN. When it is defined, trivial cases
// skip the iteration: divide by zero, signed overflow, and multiply by zero.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   start   in   request, accepted only while ready=1
//   op      in   RISC-V funct3 (0 MUL .. 7 REMU)
//   a, b    in   rs1 / rs2 operands
//   abort   in   cancels an in-flight operation (CALC or FIX)
//   ready   out  idle, can accept start
//   done    out  one-cycle pulse, result valid
//   result  out  result, held until overwritten by a completed operation

module rv_muldiv_seq #(
  parameter int WIDTH  = 32,
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int N  = WIDTH / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  // Multiply: {product high, product low / remaining multiplier bits}.
  // Divide: low half holds dividend bits shifting out / quotient shifting in.
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               neg_q, neg_d;    // product or quotient sign
  logic               rneg_q, rneg_d;  // remainder sign
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  // Operand decode for the accepting edge.
  logic             a_sgn_op, b_sgn_op, sa, sb, b_zero;
  logic [WIDTH-1:0] abs_a, abs_b;

  always_comb begin
    a_sgn_op = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn_op = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sa       = a_sgn_op & a[WIDTH-1];
    sb       = b_sgn_op & b[WIDTH-1];
    abs_a    = sa ? (~a + 1'b1) : a;
    abs_b    = sb ? (~b + 1'b1) : b;
    b_zero   = (b == '0);
  end

`ifdef MULDIV_FAST_EN
  // Register preloads for the shortcut cases. They make FIX produce exactly
  // the values that the full iteration would have left behind.
  logic               fast_hit, ovf;
  logic [2*WIDTH-1:0] fast_work;
  logic [WIDTH:0]     fast_rem;

  always_comb begin
    ovf      = ((op == 3'd4) || (op == 3'd6)) &&
               (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    fast_hit = op[2] ? (b_zero || ovf) : ((a == '0) || b_zero);
    fast_work = '0;
    fast_rem  = '0;
    if (op[2]) begin
      if (b_zero) begin
        fast_work = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        fast_rem  = {1'b0, abs_a};
      end else begin
        fast_work = {{WIDTH{1'b0}}, abs_a};
      end
    end
  end
`endif

  // UNROLL iteration steps, chained combinationally.
  logic [2*WIDTH-1:0] step_work;
  logic [WIDTH:0]     step_rem;
  logic [WIDTH:0]     sum, rs;
  logic               qb;

  always_comb begin
    step_work = work_q;
    step_rem  = rem_q;
    sum       = '0;
    rs        = '0;
    qb        = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op_q[2]) begin
        // Shift-add, LSB-first: add the multiplicand into the high half when
        // the current multiplier bit is set, then shift the whole pair right.
        sum       = {1'b0, step_work[2*WIDTH-1:WIDTH]} +
                    (step_work[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        step_work = {sum, step_work[WIDTH-1:1]};
      end else begin
        // Restoring step. The bit shifted out of the remainder top counts as
        // "greater than any divisor".
        rs = {step_rem[WIDTH-1:0], step_work[WIDTH-1]};
        if (step_rem[WIDTH] || (rs >= {1'b0, opnd_q})) begin
          step_rem = rs - {1'b0, opnd_q};
          qb       = 1'b1;
        end else begin
          step_rem = rs;
          qb       = 1'b0;
        end
        step_work = {step_work[2*WIDTH-1:WIDTH], step_work[WIDTH-2:0], qb};
      end
    end
  end

  // Sign fix-up and result selection.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = neg_q  ? (~work_q + 1'b1) : work_q;
    quo_fix  = neg_q  ? (~work_q[WIDTH-1:0] + 1'b1) : work_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
    case (op_q)
      3'd0:                fix_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          fix_res = quo_fix;
      default:             fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    work_d   = work_q;
    rem_d    = rem_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          opnd_d = op[2] ? abs_b : abs_a;
          work_d = {{WIDTH{1'b0}}, (op[2] ? abs_a : abs_b)};
          rem_d  = '0;
          // A zero divisor yields an all-ones quotient whatever the signs,
          // so the quotient must not be negated in that case.
          neg_d  = op[2] ? ((sa ^ sb) & ~b_zero) : (sa ^ sb);
          rneg_d = sa;
          cnt_d  = '0;
          state_d = S_CALC;
`ifdef MULDIV_FAST_EN
          if (fast_hit) begin
            work_d  = fast_work;
            rem_d   = fast_rem;
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          work_d = step_work;
          rem_d  = step_rem;
          if (cnt_q == CW'(N-1)) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!abort) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// tb/tb_rv_muldiv_seq.sv - self-checking bench for rv_muldiv_seq (32x1 and 16x4)

module tb_rv_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start32, abort32, ready32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, result32;
  logic        start16, abort16, ready16, done16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;

  int total = 0;
  int bad   = 0;

  rv_muldiv_seq #(.WIDTH(32), .UNROLL(1)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .abort(abort32), .ready(ready32), .done(done32), .result(result32)
  );

  rv_muldiv_seq #(.WIDTH(16), .UNROLL(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .a(a16), .b(b16),
    .abort(abort16), .ready(ready16), .done(done16), .result(result16)
  );

  // Reference: RISC-V M semantics computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_m(input int w, input logic [2:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mask, half, ux, uy, pu, r;
    longint      sx, sy, ps;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    ux = {32'd0, x} & mask;
    uy = {32'd0, y} & mask;
    sx = longint'(ux ^ half) - longint'(half);
    sy = longint'(uy ^ half) - longint'(half);
    r  = '0;
    case (o)
      3'd0: begin pu = ux * uy; r = pu & mask; end
      3'd1: begin ps = sx * sy; r = 64'(ps >>> w) & mask; end
      3'd2: begin ps = sx * longint'(uy); r = 64'(ps >>> w) & mask; end
      3'd3: begin pu = ux * uy; r = (pu >> w) & mask; end
      3'd4: begin
        if (uy == 0) r = mask;
        else if (sx == -longint'(half) && sy == -1) r = ux;
        else r = 64'(sx / sy) & mask;
      end
      3'd5: r = (uy == 0) ? mask : (ux / uy);
      3'd6: begin
        if (uy == 0) r = ux;
        else if (sx == -longint'(half) && sy == -1) r = 64'd0;
        else r = 64'(sx % sy) & mask;
      end
      default: r = (uy == 0) ? ux : (ux % uy);
    endcase
    return r[31:0];
  endfunction

`ifdef MULDIV_FAST_EN
  function automatic bit is_fast(input int w, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
    logic [31:0] mask, minv, xm, ym;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    minv = 32'd1 << (w - 1);
    xm = x & mask;
    ym = y & mask;
    if (o[2]) return (ym == 0) || (((o == 3'd4) || (o == 3'd6)) && xm == minv && ym == mask);
    return (xm == 0) || (ym == 0);
  endfunction
`endif

  function automatic int exp_lat(input int w, input int n, input logic [2:0] o,
                                 input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_FAST_EN
    if (is_fast(w, o, x, y)) return 1;
`endif
    return n + 1;
  endfunction

  // Issue one operation on the 32-bit unit, wait for done (bounded).
  task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output bit to);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(posedge clk); #1;
    start32 = 1'b0; op32 = 3'($urandom); a32 = $urandom; b32 = $urandom;
    res = '0; lat = 0; to = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done32) begin lat = k; res = result32; to = 1'b0; break; end
    end
    if (to) begin
      @(negedge clk); abort32 = 1'b1;
      @(posedge clk); #1; abort32 = 1'b0;
    end
  endtask

  task automatic run16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] res, output int lat, output bit to);
    @(negedge clk);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y;
    @(posedge clk); #1;
    start16 = 1'b0; op16 = 3'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
    res = '0; lat = 0; to = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done16) begin lat = k; res = result16; to = 1'b0; break; end
    end
    if (to) begin
      @(negedge clk); abort16 = 1'b1;
      @(posedge clk); #1; abort16 = 1'b0;
    end
  endtask

  task automatic test_reset();
    total++; if (ready32 !== 1'b1) begin bad++; $display("FAIL reset_ready32 got=%b want=1", ready32); end
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done32 got=%b want=0", done32); end
    total++; if (result32 !== 32'd0) begin bad++; $display("FAIL reset_result32 got=%h want=0", result32); end
    total++; if (ready16 !== 1'b1) begin bad++; $display("FAIL reset_ready16 got=%b want=1", ready16); end
    total++; if (done16 !== 1'b0) begin bad++; $display("FAIL reset_done16 got=%b want=0", done16); end
    total++; if (result16 !== 16'd0) begin bad++; $display("FAIL reset_result16 got=%h want=0", result16); end
  endtask

  // Directed 32-bit cases with constant expected results.
  task automatic test_directed();
    logic [2:0]  ops [10] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] xa  [10] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234_5678, 32'h1234_5678,
                              32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] xb  [10] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] xr  [10] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                              32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000,
                              32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    int lat, el;
    bit to;
    for (int i = 0; i < 10; i++) begin
      run32(ops[i], xa[i], xb[i], res, lat, to);
      el = exp_lat(32, 32, ops[i], xa[i], xb[i]);
      total++;
      if (to) begin bad++; $display("FAIL dir%0d_timeout no done within 200 cycles", i); end
      else if (res !== xr[i]) begin bad++; $display("FAIL dir%0d_result op=%0d got=%h want=%h", i, ops[i], res, xr[i]); end
      total++;
      if (lat != el) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, el); end
    end
  endtask

  // start while busy is ignored; then a back-to-back start on the done cycle.
  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    bit to;
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    for (int k = 1; k <= 4; k++) @(posedge clk);
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd9; b32 = 32'd3;
    @(posedge clk); #1;
    start32 = 1'b0;
    total++; if (ready32 !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b want=0", ready32); end
    lat = 0; to = 1'b1;
    for (int k = 6; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done32) begin lat = k; to = 1'b0; break; end
    end
    total++;
    if (to) begin bad++; $display("FAIL busy_timeout no done within 200 cycles"); end
    else if (result32 !== 32'd14) begin bad++; $display("FAIL busy_result got=%0d want=14", result32); end
    total++; if (lat != 33) begin bad++; $display("FAIL busy_latency got=%0d want=33", lat); end
    total++; if (ready32 !== 1'b1) begin bad++; $display("FAIL done_ready got=%b want=1", ready32); end
    run32(3'd7, 32'd100, 32'd7, res, lat, to);
    total++;
    if (to) begin bad++; $display("FAIL b2b_timeout no done within 200 cycles"); end
    else if (res !== 32'd2) begin bad++; $display("FAIL b2b_result got=%0d want=2", res); end
    total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
  endtask

  // Abort at edge 10, then reset at edge 10; neither may produce done.
  task automatic test_abort_reset();
    bit seen;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      start32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd5;
      @(posedge clk); #1;
      start32 = 1'b0;
      for (int k = 1; k <= 9; k++) @(posedge clk);
      @(negedge clk);
      if (pass == 0) abort32 = 1'b1; else rst_n = 1'b0;
      @(posedge clk); #1;
      abort32 = 1'b0; rst_n = 1'b1;
      total++; if (ready32 !== 1'b1) begin bad++; $display("FAIL cancel%0d_ready got=%b want=1", pass, ready32); end
      total++; if (done32 !== 1'b0) begin bad++; $display("FAIL cancel%0d_done got=%b want=0", pass, done32); end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done32) seen = 1'b1;
      end
      total++; if (seen) begin bad++; $display("FAIL cancel%0d_late_done got=1 want=0", pass); end
      total++;
      if (result32 !== ((pass == 0) ? 32'd2 : 32'd0)) begin
        bad++; $display("FAIL cancel%0d_result got=%0d want=%0d", pass, result32, (pass == 0) ? 2 : 0);
      end
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random16();
    logic [15:0] x, y, res, want;
    logic [31:0] full;
    logic [2:0]  o;
    int lat, el;
    bit to;
    for (int i = 0; i < 48; i++) begin
      o = (i < 8) ? 3'(i) : 3'($urandom);
      x = pick16();
      y = pick16();
      full = ref_m(16, o, {16'd0, x}, {16'd0, y});
      want = full[15:0];
      el = exp_lat(16, 4, o, {16'd0, x}, {16'd0, y});
      run16(o, x, y, res, lat, to);
      total++;
      if (to) begin bad++; $display("FAIL rnd%0d_timeout no done within 200 cycles", i); end
      else if (res !== want) begin
        bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, o, x, y, res, want);
      end
      total++;
      if (lat != el) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, el); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; abort32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start16 = 1'b0; abort16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort_reset();
    test_random16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
